// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round controller: sequences IDLE/PLAY/OVER, schedules mole
// visibility from the random source, validates hits, and counts the
// remaining round time in BCD.
module mole_round_scheduler #(
    parameter int NUM_HOLES     = 10,
    parameter int UP_TICKS      = 80,
    parameter int GAP_TICKS     = 20,
    parameter int TICKS_PER_SEC = 100,
    parameter int GAME_SECONDS  = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 pb_start_op,
    input  logic                 pb_clear_op,
    input  logic [5:0]           rnd,
    input  logic                 hit_valid,
    input  logic [3:0]           hit_idx,
    output logic [NUM_HOLES-1:0] led,
    output logic [1:0]           state,
    output logic                 add_score,
    output logic [3:0]           time1,
    output logic [3:0]           time0
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    typedef enum logic {
        PH_GAP = 1'b0,
        PH_UP  = 1'b1
    } phase_e;

    localparam int PH_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int CW     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
    localparam int PW     = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [CW-1:0] UP_LAST  = CW'(UP_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] SEC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    T1_INIT  = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    T0_INIT  = 4'(GAME_SECONDS % 10);
    localparam logic [3:0]    NO_HOLE  = 4'd15;
    localparam logic [3:0]    N_HOLES  = 4'(NUM_HOLES);
    localparam logic [3:0]    LAST_HOLE = 4'(NUM_HOLES - 1);
    localparam logic [NUM_HOLES-1:0] LED_ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [3:0]           t1_q, t1_d;
    logic [3:0]           t0_q, t0_d;
    logic [3:0]           prev_q, prev_d;
    logic [NUM_HOLES-1:0] led_q, led_d;
    logic                 add_score_q, add_score_d;

    logic [3:0] rnd_lo;
    logic [3:0] base_idx;
    logic [3:0] sel_idx;
    logic       timed_out;
    logic       rnd_unused;

    // Only the low nibble of the random value picks a hole.
    assign rnd_unused = ^rnd[5:4];

    // Fold the random nibble onto 0..9 and step past the previous hole.
    always_comb begin
        rnd_lo   = rnd[3:0];
        base_idx = (rnd_lo < N_HOLES) ? rnd_lo : (rnd_lo - N_HOLES);
        sel_idx  = base_idx;
        if (base_idx == prev_q) begin
            sel_idx = (base_idx == LAST_HOLE) ? 4'd0 : (base_idx + 4'd1);
        end
    end

    // Round FSM, mole sub-phase and BCD timer; timeout outranks a hit,
    // and clear outranks everything.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        t1_d        = t1_q;
        t0_d        = t0_q;
        prev_d      = prev_q;
        led_d       = led_q;
        add_score_d = 1'b0;
        timed_out   = 1'b0;

        if (pb_clear_op) begin
            state_d = ST_IDLE;
            phase_d = PH_GAP;
            cnt_d   = '0;
            presc_d = '0;
            t1_d    = T1_INIT;
            t0_d    = T0_INIT;
            prev_d  = NO_HOLE;
            led_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (pb_start_op) begin
                        state_d = ST_PLAY;
                        phase_d = PH_GAP;
                        cnt_d   = '0;
                        presc_d = '0;
                        t1_d    = T1_INIT;
                        t0_d    = T0_INIT;
                        prev_d  = NO_HOLE;
                        led_d   = '0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (presc_q == SEC_LAST) begin
                            presc_d = '0;
                            if (t0_q == 4'd0) begin
                                t0_d = 4'd9;
                                t1_d = t1_q - 4'd1;
                            end else begin
                                t0_d = t0_q - 4'd1;
                            end
                            if (t1_q == 4'd0 && t0_q == 4'd1) begin
                                timed_out = 1'b1;
                                state_d   = ST_OVER;
                                phase_d   = PH_GAP;
                                cnt_d     = '0;
                                led_d     = '0;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                    if (!timed_out) begin
                        if (hit_valid && phase_q == PH_UP && hit_idx == prev_q) begin
                            add_score_d = 1'b1;
                            led_d       = '0;
                            phase_d     = PH_GAP;
                            cnt_d       = '0;
                        end else if (tick) begin
                            if (phase_q == PH_GAP) begin
                                if (cnt_q == GAP_LAST) begin
                                    led_d   = LED_ONE << sel_idx;
                                    prev_d  = sel_idx;
                                    phase_d = PH_UP;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                            end else begin
                                if (cnt_q == UP_LAST) begin
                                    led_d   = '0;
                                    phase_d = PH_GAP;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset to the idle round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_GAP;
            cnt_q       <= '0;
            presc_q     <= '0;
            t1_q        <= T1_INIT;
            t0_q        <= T0_INIT;
            prev_q      <= NO_HOLE;
            led_q       <= '0;
            add_score_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            t1_q        <= t1_d;
            t0_q        <= t0_d;
            prev_q      <= prev_d;
            led_q       <= led_d;
            add_score_q <= add_score_d;
        end
    end

    assign state     = state_q;
    assign led       = led_q;
    assign add_score = add_score_q;
    assign time1     = t1_q;
    assign time0     = t0_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Randomised bench for mole_round_scheduler: a cycle-level reference model
// written with plain integers predicts every output, a monitor compares.
module tb_mole_round_scheduler;

    localparam int GS   = 30;
    localparam int TPS  = 100;
    localparam int UPT  = 80;
    localparam int GAPT = 20;
    localparam int NH   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       pb_start_op;
    logic       pb_clear_op;
    logic [5:0] rnd;
    logic       hit_valid;
    logic [3:0] hit_idx;
    logic [9:0] led;
    logic [1:0] state;
    logic       add_score;
    logic [3:0] time1;
    logic [3:0] time0;

    // Clock
    always #5 clk = ~clk;

    mole_round_scheduler #(
        .NUM_HOLES(NH), .UP_TICKS(UPT), .GAP_TICKS(GAPT),
        .TICKS_PER_SEC(TPS), .GAME_SECONDS(GS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .pb_start_op(pb_start_op), .pb_clear_op(pb_clear_op),
        .rnd(rnd), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .led(led), .state(state), .add_score(add_score),
        .time1(time1), .time0(time0)
    );

    logic [20:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 play, 2 over; hole -1 means no mole.
    int m_state;
    int m_secs;
    int m_sec_ticks;
    bit m_up;
    int m_phase_ticks;
    int m_hole;
    int m_prev;
    bit m_score;

    task automatic model_reset();
        m_state = 0; m_secs = GS; m_sec_ticks = 0; m_up = 0;
        m_phase_ticks = 0; m_hole = -1; m_prev = 15; m_score = 0;
    endtask

    function automatic int pick_hole(input logic [5:0] r);
        int idx;
        idx = int'(r) % 16;
        idx = idx % NH;
        if (idx == m_prev) idx = (idx + 1) % NH;
        return idx;
    endfunction

    task automatic model_step(input bit st, input bit cl, input bit tk,
                              input logic [5:0] r, input bit hv, input logic [3:0] hi);
        bit done;
        m_score = 0;
        done = 0;
        if (cl) begin
            model_reset();
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_secs = GS; m_sec_ticks = 0; m_up = 0;
                m_phase_ticks = 0; m_hole = -1; m_prev = 15;
            end
        end else begin
            if (tk) begin
                m_sec_ticks++;
                if (m_sec_ticks == TPS) begin
                    m_sec_ticks = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_state = 2; m_hole = -1; m_up = 0; done = 1;
                    end
                end
            end
            if (!done) begin
                if (hv && m_up && int'(hi) == m_hole) begin
                    m_score = 1; m_hole = -1; m_up = 0; m_phase_ticks = 0;
                end else if (tk) begin
                    m_phase_ticks++;
                    if (!m_up && m_phase_ticks == GAPT) begin
                        m_hole = pick_hole(r); m_prev = m_hole;
                        m_up = 1; m_phase_ticks = 0;
                    end else if (m_up && m_phase_ticks == UPT) begin
                        m_hole = -1; m_up = 0; m_phase_ticks = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [20:0] model_out();
        logic [9:0] l;
        l = (m_hole < 0) ? 10'd0 : (10'd1 << m_hole);
        return {2'(m_state), l, m_score, 4'(m_secs / 10), 4'(m_secs % 10)};
    endfunction

    // Monitor: each cycle compare the registered outputs against the oldest prediction
    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, led, add_score, time1, time0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_chk t=%0t act st=%b led=%b sc=%b t=%h%h exp st=%b led=%b sc=%b t=%h%h",
                         $time, a[20:19], a[18:9], a[8], a[7:4], a[3:0],
                         e[20:19], e[18:9], e[8], e[7:4], e[3:0]);
            end
        end
    end

    // Driver: one call is one clock cycle of inputs
    task automatic drive(input bit st, input bit cl, input bit tk,
                         input logic [5:0] r, input bit hv, input logic [3:0] hi);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pb_start_op = st; pb_clear_op = cl; tick = tk;
        rnd = r; hit_valid = hv; hit_idx = hi;
        model_step(st, cl, tk, r, hv, hi);
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset();
        logic [20:0] a;
        @(negedge clk);
        #1;
        rst = 1'b1;
        pb_start_op = 0; pb_clear_op = 0; tick = 0;
        rnd = '0; hit_valid = 0; hit_idx = '0;
        model_reset();
        #1;
        a = {state, led, add_score, time1, time0};
        checks++;
        if (a !== {2'b00, 10'd0, 1'b0, 4'd3, 4'd0}) begin
            errors++;
            $display("FAIL async_reset act=%h exp=%h", a, {2'b00, 10'd0, 1'b0, 4'd3, 4'd0});
        end
        exp_q.push_back(model_out());
    endtask

    task automatic rand_hit(output bit hv, output logic [3:0] hi);
        hv = ($urandom_range(0, 3) == 0);
        if (m_hole >= 0 && $urandom_range(0, 2) == 0) hi = 4'(m_hole);
        else hi = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_mole();
        for (int i = 0; i < 200 && m_hole < 0; i++) drive(0, 0, 1, 6'($urandom_range(0, 63)), 0, 4'd0);
    endtask

    initial begin
        bit hv;
        logic [3:0] hi;
        rst = 1'b1; pb_start_op = 0; pb_clear_op = 0; tick = 0;
        rnd = '0; hit_valid = 0; hit_idx = '0;
        model_reset();
        do_reset();

        // Idle: random hits must change nothing
        for (int i = 0; i < 20; i++)
            drive(0, 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // Start with rnd=13: hole 3 after 20 ticks, hit it, then a GAP hit
        drive(1, 0, 0, 6'd13, 0, 4'd0);
        for (int i = 0; i < GAPT; i++) drive(0, 0, 1, 6'd13, 0, 4'd0);
        drive(0, 0, 0, 6'd13, 1, 4'd3);
        drive(0, 0, 0, 6'd13, 1, 4'd3);

        // Put hole 9 up and hit it, then the same nibble must step to hole 0
        for (int i = 0; i < GAPT; i++) drive(0, 0, 1, 6'h09, 0, 4'd0);
        drive(0, 0, 0, 6'h09, 1, 4'd9);
        for (int i = 0; i < GAPT; i++) drive(0, 0, 1, 6'h19, 0, 4'd0);
        drive(0, 0, 0, 6'h19, 1, 4'd5);
        for (int i = 0; i < UPT; i++) drive(0, 0, 1, 6'h19, 0, 4'd0);

        // Hit on the same tick as UP expiry: the hit scores
        for (int i = 0; i < GAPT; i++) drive(0, 0, 1, 6'($urandom_range(0, 63)), 0, 4'd0);
        for (int i = 0; i < UPT - 1; i++) drive(0, 0, 1, 6'($urandom_range(0, 63)), 0, 4'd0);
        drive(0, 0, 1, 6'd0, 1, 4'(m_hole));

        // Full round with continuous ticks, only wrong-index hits,
        // and a correct hit on the final timer tick
        drive(0, 1, 0, 6'd0, 0, 4'd0);
        drive(1, 0, 0, 6'd0, 0, 4'd0);
        for (int i = 0; i < GS * TPS; i++) begin
            if (i == GS * TPS - 1) begin
                hv = 1;
                hi = (m_hole >= 0) ? 4'(m_hole) : 4'd0;
            end else begin
                hv = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) hi = 4'($urandom_range(10, 15));
                else if (m_hole >= 0) hi = 4'((m_hole + $urandom_range(1, 9)) % NH);
                else hi = 4'($urandom_range(0, 15));
            end
            drive(0, 0, 1, 6'($urandom_range(0, 63)), hv, hi);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 6'($urandom_range(0, 63)), 1, 4'($urandom_range(0, 9)));
        drive(1, 0, 0, 6'd0, 0, 4'd0);
        drive(1, 0, 1, 6'd0, 0, 4'd0);

        // Random play
        for (int i = 0; i < 1500; i++) begin
            rand_hit(hv, hi);
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), hv, hi);
        end

        // Clear and start together with a mole up
        drive(0, 1, 0, 6'd0, 0, 4'd0);
        drive(1, 0, 0, 6'd0, 0, 4'd0);
        wait_mole();
        drive(1, 1, 1, 6'd0, 1, 4'(m_hole));
        drive(0, 0, 0, 6'd0, 0, 4'd0);

        // Reset during UP
        drive(1, 0, 0, 6'd0, 0, 4'd0);
        wait_mole();
        drive(0, 0, 1, 6'd0, 1, 4'(m_hole >= 0 ? m_hole + 1 : 0));
        do_reset();
        drive(0, 0, 0, 6'd0, 0, 4'd0);
        drive(0, 0, 1, 6'd0, 1, 4'd3);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
